// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/synchroniser block.
package debounce_pkg;

  // Defaults used when the top-level parameters are not overridden
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Two stable levels plus one "pending" state per direction
  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
// Reusable on its own; the output is the last flop of the chain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the chain; stage 0 is the metastable-risk flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise a bouncy external level and accept a new level only after it
// has been seen for DEBOUNCE_CYCLES consecutive synchronised samples.
// A pending change that breaks early is dropped with a one-cycle glitch_o.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic busy_o,
  output logic glitch_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync;
  debounce_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            clean_q;
  logic            busy_q;
  logic            glitch_q;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (raw_i),
    .q_o     (sync)
  );

  // Qualification FSM; counter and all outputs are registered with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      glitch_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (sync) begin
            state_q <= PEND_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync) begin
            state_q <= PEND_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        PEND_HIGH: begin
          if (sync) begin
            if (cnt_q == CNT_MAX) begin
              state_q <= ST_HIGH;
              clean_q <= 1'b1;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            // Level broke before qualification: fall back, keep clean_o
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            glitch_q <= 1'b1;
          end
        end
        PEND_LOW: begin
          if (!sync) begin
            if (cnt_q == CNT_MAX) begin
              state_q <= ST_LOW;
              clean_q <= 1'b0;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            state_q  <= ST_HIGH;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            glitch_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clean_o  = clean_q;
  assign busy_o   = busy_q;
  assign glitch_o = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus random
// bouncing, compared cycle by cycle against a run-length reference model.
module tb_debounce_sync;

  localparam int S = 2;
  localparam int N = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic raw_i   = 1'b0;
  logic clean_o;
  logic busy_o;
  logic glitch_o;

  debounce_sync #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (raw_i),
    .clean_o  (clean_o),
    .busy_o   (busy_o),
    .glitch_o (glitch_o)
  );

  // 100 MHz
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: raw delayed by S edges, then a level is accepted once
  // N consecutive delayed samples disagree with the current clean level.
  logic m_pipe [S];
  logic m_clean;
  logic m_glitch;
  int   m_run;

  int   step_no = 0;
  bit   lat_en  = 1'b0;
  int   chg_q[$];
  logic prev_raw   = 1'b0;
  logic prev_clean = 1'b0;
  int   glitch_seen, busy_seen, rise_seen, fall_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (step %0d, t=%0t)", tag, obs, exp, step_no, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_pipe[i] = 1'b0;
    m_clean  = 1'b0;
    m_glitch = 1'b0;
    m_run    = 0;
  endtask

  task automatic model_edge(input logic raw);
    logic seen;
    seen = m_pipe[S-1];
    for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = raw;
    m_glitch  = 1'b0;
    if (seen != m_clean) begin
      m_run++;
      if (m_run == N) begin
        m_clean = seen;
        m_run   = 0;
      end
    end else if (m_run > 0) begin
      m_glitch = 1'b1;
      m_run    = 0;
    end
  endtask

  task automatic clear_stats();
    glitch_seen = 0;
    busy_seen   = 0;
    rise_seen   = 0;
    fall_seen   = 0;
    chg_q.delete();
  endtask

  // One clock: called at a negedge, drives raw 1 ns later, checks at next negedge
  task automatic step(input logic v);
    int c;
    #1 raw_i = v;
    if (lat_en && (v !== prev_raw)) chg_q.push_back(step_no);
    prev_raw = v;
    @(posedge clk);
    if (reset_n) model_edge(v);
    @(negedge clk);
    check_val("clean_o", clean_o, m_clean);
    check_val("busy_o", busy_o, (m_run > 0));
    check_val("glitch_o", glitch_o, m_glitch);
    if (glitch_o) glitch_seen++;
    if (busy_o) busy_seen++;
    if (clean_o !== prev_clean) begin
      if (clean_o) rise_seen++;
      else fall_seen++;
      if (lat_en) begin
        if (chg_q.size() != 0) begin
          c = chg_q.pop_front();
          check_val("latency", step_no - c + 1, S + N);
        end else begin
          check_val("edge_without_change", chg_q.size(), 1);
        end
      end
    end
    prev_clean = clean_o;
    step_no++;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release at next negedge
  task automatic do_reset(input logic raw_during);
    #2 reset_n = 1'b0;
    raw_i = raw_during;
    prev_raw = raw_during;
    #1;
    check_val("rst_clean_o", clean_o, 1'b0);
    check_val("rst_busy_o", busy_o, 1'b0);
    check_val("rst_glitch_o", glitch_o, 1'b0);
    model_reset();
    prev_clean = 1'b0;
    @(negedge clk);
    check_val("rst_held_glitch_o", glitch_o, 1'b0);
    reset_n = 1'b1;
  endtask

  logic [19:0] pattern;
  int exp_rise, exp_fall;
  logic cur, bit_v;

  initial begin
    model_reset();
    clear_stats();
    @(negedge clk);
    @(negedge clk);
    check_val("init_clean_o", clean_o, 1'b0);
    check_val("init_busy_o", busy_o, 1'b0);
    check_val("init_glitch_o", glitch_o, 1'b0);
    reset_n = 1'b1;

    // Quiet low after release
    hold(1'b0, 10);
    check_val("quiet_busy_cycles", busy_seen, 0);
    check_val("quiet_glitches", glitch_seen, 0);
    check_val("quiet_rises", rise_seen, 0);

    // Clean rise then clean fall, latency checked on each edge
    lat_en = 1'b1;
    clear_stats();
    hold(1'b1, 10);
    check_val("rise_busy_cycles", busy_seen, N - 1);
    check_val("rise_count", rise_seen, 1);
    check_val("rise_glitches", glitch_seen, 0);
    check_val("rise_final_clean", clean_o, 1'b1);
    clear_stats();
    hold(1'b0, 10);
    check_val("fall_count", fall_seen, 1);
    check_val("fall_glitches", glitch_seen, 0);

    // Short pulse must be rejected
    lat_en = 1'b0;
    clear_stats();
    hold(1'b1, 2);
    hold(1'b0, 8);
    check_val("pulse_rises", rise_seen, 0);
    check_val("pulse_glitches", glitch_seen, 1);
    check_val("pulse_busy_end", busy_o, 1'b0);

    // Bounce then settle high
    clear_stats();
    pattern = 20'b1011011111;
    for (int i = 9; i >= 0; i--) begin
      bit_v = pattern[i];
      step(bit_v);
    end
    hold(1'b1, 6);
    check_val("bounce_rises", rise_seen, 1);
    check_val("bounce_glitches", glitch_seen, 2);
    check_val("bounce_clean", clean_o, 1'b1);

    // Reset while a fall is pending
    clear_stats();
    hold(1'b0, 3);
    check_val("pend_low_busy", busy_o, 1'b1);
    check_val("pend_low_clean", clean_o, 1'b1);
    do_reset(1'b0);
    hold(1'b0, 10);
    check_val("after_rst_rises", rise_seen, 0);
    check_val("after_rst_glitches", glitch_seen, 0);
    check_val("after_rst_clean", clean_o, 1'b0);

    // Raw already high at reset release
    do_reset(1'b1);
    lat_en = 1'b1;
    clear_stats();
    chg_q.push_back(step_no);
    hold(1'b1, 8);
    check_val("rel_high_rises", rise_seen, 1);

    // Serial pattern, one bit per 8 cycles, edges after fixed latency
    hold(1'b0, 10);
    clear_stats();
    pattern = 20'h1F07C;
    exp_rise = 0;
    exp_fall = 0;
    cur = 1'b0;
    for (int i = 19; i >= 0; i--) begin
      bit_v = pattern[i];
      if (bit_v && !cur) exp_rise++;
      if (!bit_v && cur) exp_fall++;
      cur = bit_v;
      hold(bit_v, 8);
    end
    hold(1'b0, 8);
    check_val("pattern_rises", rise_seen, exp_rise);
    check_val("pattern_falls", fall_seen, exp_fall);
    check_val("pattern_glitches", glitch_seen, 0);

    // Random bouncing: runs of 1..7 cycles
    lat_en = 1'b0;
    clear_stats();
    for (int r = 0; r < 80; r++) begin
      bit_v = 1'($urandom_range(0, 1));
      hold(bit_v, $urandom_range(1, 7));
    end
    hold(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
